// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-digit packed-BCD up/down counter with integrated tick prescaler
module bcd_counter_n #(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] MAX_VALUE = 16'h9675,
    parameter int                  TICK_DIV  = 50000000,
    parameter bit                  WRAP      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena_in,
    input  logic                  clr,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Qdata,
    output logic                  tick_out,
    output logic                  terminal,
    output logic                  load_err
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic          carry;
    logic          borrow;
    logic          load_ok;
    logic          at_max;
    logic          at_zero;
    logic          step;

    // Free-running prescaler; tick_out is registered so it follows the terminal prescaler count by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= (presc == PRESC_LAST);
            if (presc == PRESC_LAST)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

    // Next-value candidates: rippled BCD increment/decrement and load validation
    always_comb begin
        inc_val = Qdata;
        dec_val = Qdata;
        carry   = 1'b1;
        borrow  = 1'b1;
        load_ok = (load_val <= MAX_VALUE);
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (Qdata[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = Qdata[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (Qdata[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = Qdata[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9)
                load_ok = 1'b0;
        end
    end

    assign at_max  = (Qdata == MAX_VALUE);
    assign at_zero = (Qdata == '0);
    assign step    = tick_out && ena_in;

    // Count register with clr > load > step priority; terminal/load_err are single-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Qdata    <= '0;
            terminal <= 1'b0;
            load_err <= 1'b0;
        end else begin
            terminal <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                Qdata <= '0;
            end else if (load) begin
                if (load_ok)
                    Qdata <= load_val;
                else
                    load_err <= 1'b1;
            end else if (step) begin
                if (up_dn) begin
                    if (at_max) begin
                        terminal <= 1'b1;
                        if (WRAP)
                            Qdata <= '0;
                    end else begin
                        Qdata <= inc_val;
                    end
                end else begin
                    if (at_zero) begin
                        terminal <= 1'b1;
                        if (WRAP)
                            Qdata <= MAX_VALUE;
                    end else begin
                        Qdata <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - scoreboard bench for bcd_counter_n against a decimal reference model
module tb_bcd_counter_n;

    localparam int NI      = 3;
    localparam int MAX_DEC = 9675;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena_in = 1'b0;
    logic        clr = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;

    logic [15:0] q_w, q_s, q_p;
    logic        tk_w, tk_s, tk_p;
    logic        tm_w, tm_s, tm_p;
    logic        le_w, le_s, le_p;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(4), .MAX_VALUE(16'h9675), .TICK_DIV(1), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .ena_in(ena_in), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Qdata(q_w), .tick_out(tk_w), .terminal(tm_w), .load_err(le_w));

    bcd_counter_n #(.DIGITS(4), .MAX_VALUE(16'h9675), .TICK_DIV(1), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .ena_in(ena_in), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Qdata(q_s), .tick_out(tk_s), .terminal(tm_s), .load_err(le_s));

    bcd_counter_n #(.DIGITS(4), .MAX_VALUE(16'h9675), .TICK_DIV(5), .WRAP(1'b1)) dut_p (
        .clk(clk), .rst(rst), .ena_in(ena_in), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .Qdata(q_p), .tick_out(tk_p), .terminal(tm_p), .load_err(le_p));

    typedef struct {
        logic [47:0] q;
        logic [2:0]  tick;
        logic [2:0]  term;
        logic [2:0]  lerr;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    int mval [NI];
    int kcnt [NI];
    bit mtick[NI];
    bit mterm[NI];
    bit mlerr[NI];

    function automatic int td_of(int i);
        return (i == 2) ? 5 : 1;
    endfunction

    function automatic bit wrap_of(int i);
        return (i != 1);
    endfunction

    function automatic logic [15:0] dec2bcd(int v);
        logic [15:0] r;
        int div;
        div = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    // Decimal value of a packed-BCD word; returns 0 in ok if any nibble is not a decimal digit
    function automatic int bcd2dec(logic [15:0] x, output bit ok);
        int v;
        int div;
        v   = 0;
        div = 1;
        ok  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (x[4*i +: 4] > 4'd9) ok = 1'b0;
            v   = v + int'(x[4*i +: 4]) * div;
            div = div * 10;
        end
        return v;
    endfunction

    task automatic model_edge();
        bit prev_tick;
        bit ok;
        int v;
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                mval[i] = 0; kcnt[i] = 0; mtick[i] = 0; mterm[i] = 0; mlerr[i] = 0;
            end else begin
                prev_tick = mtick[i];
                mterm[i]  = 0;
                mlerr[i]  = 0;
                if (clr) begin
                    mval[i] = 0;
                end else if (load) begin
                    v = bcd2dec(load_val, ok);
                    if (ok && v <= MAX_DEC) mval[i] = v;
                    else mlerr[i] = 1;
                end else if (prev_tick && ena_in) begin
                    if (up_dn) begin
                        if (mval[i] == MAX_DEC) begin
                            mterm[i] = 1;
                            if (wrap_of(i)) mval[i] = 0;
                        end else mval[i] = mval[i] + 1;
                    end else begin
                        if (mval[i] == 0) begin
                            mterm[i] = 1;
                            if (wrap_of(i)) mval[i] = MAX_DEC;
                        end else mval[i] = mval[i] - 1;
                    end
                end
                kcnt[i]  = kcnt[i] + 1;
                mtick[i] = ((kcnt[i] % td_of(i)) == 0);
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        for (int i = 0; i < NI; i++) begin
            e.q[16*i +: 16] = dec2bcd(mval[i]);
            e.tick[i] = mtick[i];
            e.term[i] = mterm[i];
            e.lerr[i] = mlerr[i];
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic drv(input bit c, input bit l, input logic [15:0] lv, input bit en, input bit up);
        clr = c; load = l; load_val = lv; ena_in = en; up_dn = up;
    endtask

    // Monitor: one scoreboard entry per clock, compared away from the active edge
    initial begin
        exp_t e;
        logic [15:0] aq;
        logic at, am, al;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NI; i++) begin
                    case (i)
                        0:       begin aq = q_w; at = tk_w; am = tm_w; al = le_w; end
                        1:       begin aq = q_s; at = tk_s; am = tm_s; al = le_s; end
                        default: begin aq = q_p; at = tk_p; am = tm_p; al = le_p; end
                    endcase
                    n_vec++;
                    if (aq !== e.q[16*i +: 16] || at !== e.tick[i] || am !== e.term[i] || al !== e.lerr[i]) begin
                        n_err++;
                        $display("FAIL outputs inst%0d t=%0t: got q=%h tick=%b term=%b lerr=%b, want q=%h tick=%b term=%b lerr=%b",
                                 i, $time, aq, at, am, al, e.q[16*i +: 16], e.tick[i], e.term[i], e.lerr[i]);
                    end
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    int r;
    logic [15:0] lv;

    initial begin
        drv(0, 0, 16'h0, 0, 1);
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;

        // count up across the digit-0 carry
        drv(0, 0, 16'h0, 1, 1);
        repeat (14) cycle();
        drv(0, 1, 16'h0999, 1, 1); cycle();
        drv(0, 0, 16'h0, 1, 1); repeat (6) cycle();

        // upper boundary
        drv(0, 1, 16'h9674, 1, 1); cycle();
        drv(0, 0, 16'h0, 1, 1); repeat (12) cycle();

        // lower boundary and borrow
        drv(0, 1, 16'h0000, 1, 0); cycle();
        drv(0, 0, 16'h0, 1, 0); repeat (8) cycle();
        drv(0, 1, 16'h1000, 1, 0); cycle();
        drv(0, 0, 16'h0, 1, 0); repeat (6) cycle();

        // rejected loads and clr priority
        drv(0, 1, 16'h12A4, 0, 1); cycle();
        drv(0, 1, 16'h9676, 0, 1); cycle();
        drv(0, 0, 16'h0, 0, 1); cycle();
        drv(1, 1, 16'h5555, 1, 1); cycle();
        drv(1, 1, 16'hFFFF, 1, 1); cycle();
        drv(0, 0, 16'h0, 1, 1); repeat (6) cycle();

        // enable toggling against the slow prescaler
        for (int i = 0; i < 40; i++) begin
            drv(0, 0, 16'h0, (i % 3) != 0, 1);
            cycle();
        end

        // asynchronous reset mid-count
        drv(0, 1, 16'h4321, 0, 1); cycle();
        drv(0, 0, 16'h0, 1, 1); cycle();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_now("async_rst q_w", q_w, 16'h0);
        check_now("async_rst q_p", q_p, 16'h0);
        check_now("async_rst pulses", {13'h0, tk_w, tm_w, le_w}, 16'h0);
        check_now("async_rst tick_p", {15'h0, tk_p}, 16'h0);
        cycle();
        cycle();
        rst = 1'b1;
        repeat (12) cycle();

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       lv = 16'($urandom);
                1:       lv = dec2bcd($urandom_range(0, 9999));
                2:       lv = dec2bcd(9670 + $urandom_range(0, 9));
                default: lv = dec2bcd($urandom_range(0, 5));
            endcase
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), lv,
                ($urandom_range(0, 4) != 0), $urandom_range(0, 1));
            cycle();
        end

        drv(0, 0, 16'h0, 0, 1);
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
